// File: rtl/io_wait_state_generator.sv
`timescale 1ns / 1ps
// ============================================================================
// io_wait_state_generator
// ----------------------------------------------------------------------------
// Purpose:
//   Stretches selected 8088 bus cycles for slow expansion I/O and memory.
//   A bus cycle is followed from ALE through the RD_N/WR_N strobe. When the
//   cycle was selected at ALE time, EXT_READY is pulled low for a fixed
//   number of CPU-clock rising edges and then released. EXT_READY feeds the
//   CPU ready synchronizer, which runs in this same system clock domain.
//
// Parameters:
//   IO_WAIT     - wait states inserted into selected I/O cycles (IO_OR_M=1)
//   MEM_WAIT    - wait states inserted into selected memory cycles
//   COUNT_WIDTH - wait counter width; both wait counts must fit in it
//
// Ports:
//   clock             in   system clock
//   reset             in   asynchronous, active-high reset
//   cpu_clock_posedge in   one-clock enable at each CPU clock rising edge
//   cpu_clock_negedge in   one-clock enable at each CPU clock falling edge
//                          (not needed here; kept for interface symmetry
//                          with the ready synchronizer)
//   ALE               in   address latch enable, active high
//   IO_OR_M           in   cycle type qualified at ALE (1=I/O, 0=memory)
//   SELECT            in   decoded slow-device select, qualified at ALE
//   RD_N              in   read strobe, active low
//   WR_N              in   write strobe, active low
//   INTA_N            in   interrupt acknowledge, active low
//   ENABLE            in   0 disables all wait insertion
//   EXT_READY         out  1 = no wait requested, 0 = hold the CPU (registered)
//   BUSY              out  1 while the cycle tracker is not idle
// ============================================================================
module io_wait_state_generator #(
    parameter int IO_WAIT     = 4,
    parameter int MEM_WAIT    = 1,
    parameter int COUNT_WIDTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_clock_posedge,
    input  logic cpu_clock_negedge,
    input  logic ALE,
    input  logic IO_OR_M,
    input  logic SELECT,
    input  logic RD_N,
    input  logic WR_N,
    input  logic INTA_N,
    input  logic ENABLE,
    output logic EXT_READY,
    output logic BUSY
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] C_IO_WAIT  = COUNT_WIDTH'(IO_WAIT);
    localparam logic [COUNT_WIDTH-1:0] C_MEM_WAIT = COUNT_WIDTH'(MEM_WAIT);
    localparam logic [COUNT_WIDTH-1:0] C_ZERO     = '0;
    localparam logic [COUNT_WIDTH-1:0] C_ONE      = COUNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic                   r_type;
    logic                   w_type_next;
    logic                   r_sel;
    logic                   w_sel_next;
    logic                   r_ready;
    logic                   w_ready_next;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   w_strobe;
    logic                   w_sel_at_ale;
    logic [COUNT_WIDTH-1:0] w_load_val;
    logic                   w_unused_ok;

    assign w_strobe = ~RD_N | ~WR_N;

    // INTA cycles and a disabled block never qualify for waits; INTA ready
    // handling belongs to the ready synchronizer.
    assign w_sel_at_ale = SELECT & ENABLE & INTA_N;

    assign w_load_val = r_type ? C_IO_WAIT : C_MEM_WAIT;

    // The falling-edge enable has no role in this FSM.
    assign w_unused_ok = cpu_clock_negedge;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_type_next  = r_type;
        w_sel_next   = r_sel;
        w_ready_next = r_ready;

        case (r_state)
            S_IDLE: begin
                w_ready_next = 1'b1;
                // ALE takes precedence over a simultaneous strobe; the
                // strobe is honoured from ARMED once ALE has dropped.
                if (ALE) begin
                    w_type_next  = IO_OR_M;
                    w_sel_next   = w_sel_at_ale;
                    w_state_next = S_ARMED;
                end
            end

            S_ARMED: begin
                if (ALE) begin
                    // Keep re-qualifying until ALE falls: the last value
                    // seen with ALE high describes the cycle.
                    w_type_next = IO_OR_M;
                    w_sel_next  = w_sel_at_ale;
                end else if (w_strobe) begin
                    if (!r_sel) begin
                        w_ready_next = 1'b1;
                        w_state_next = S_DONE;
                    end else if (w_load_val == C_ZERO) begin
                        w_count_next = C_ZERO;
                        w_ready_next = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        // Ready drops on the same clock the strobe is seen.
                        w_count_next = w_load_val;
                        w_ready_next = 1'b0;
                        w_state_next = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // ALE is deliberately ignored here.
                if (!w_strobe) begin
                    // Strobe vanished mid-wait: abandon the cycle.
                    w_count_next = C_ZERO;
                    w_ready_next = 1'b1;
                    w_state_next = S_IDLE;
                end else if (cpu_clock_posedge && (r_count != C_ZERO)) begin
                    w_count_next = r_count - C_ONE;
                    if (r_count == C_ONE) begin
                        w_ready_next = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_ready_next = 1'b1;
                if (!w_strobe) begin
                    if (ALE) begin
                        // Back-to-back cycle: qualify the new one directly.
                        w_type_next  = IO_OR_M;
                        w_sel_next   = w_sel_at_ale;
                        w_state_next = S_ARMED;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end

            default: begin
                w_count_next = C_ZERO;
                w_ready_next = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= C_ZERO;
            r_type  <= 1'b0;
            r_sel   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_type  <= w_type_next;
            r_sel   <= w_sel_next;
            r_ready <= w_ready_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: both come straight from registers.
    // ------------------------------------------------------------------
    assign EXT_READY = r_ready;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_io_wait_state_generator.sv
`timescale 1ns / 1ps
module tb_io_wait_state_generator;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_pos = 1'b0;
    logic cpu_neg = 1'b0;
    logic ALE = 1'b0;
    logic IO_OR_M = 1'b0;
    logic SELECT = 1'b0;
    logic RD_N = 1'b1;
    logic WR_N = 1'b1;
    logic INTA_N = 1'b1;
    logic ENABLE = 1'b1;
    logic EXT_READY;
    logic BUSY;

    int checks = 0;
    int errors = 0;

    localparam int K_WAIT = 0;  // end of a wait episode, value = CPU posedges held low
    localparam int K_END  = 1;  // end of a busy period

    typedef struct {
        int kind;
        int value;
    } exp_t;

    exp_t exp_q[$];

    io_wait_state_generator #(
        .IO_WAIT    (4),
        .MEM_WAIT   (1),
        .COUNT_WIDTH(4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_clock_posedge(cpu_pos),
        .cpu_clock_negedge(cpu_neg),
        .ALE              (ALE),
        .IO_OR_M          (IO_OR_M),
        .SELECT           (SELECT),
        .RD_N             (RD_N),
        .WR_N             (WR_N),
        .INTA_N           (INTA_N),
        .ENABLE           (ENABLE),
        .EXT_READY        (EXT_READY),
        .BUSY             (BUSY)
    );

    always #5 clock = ~clock;

    // CPU clock = system clock / 4
    initial begin : cpu_gen
        int phase;
        phase = 0;
        forever begin
            @(posedge clock);
            #1;
            cpu_pos = (phase == 0);
            cpu_neg = (phase == 2);
            phase = (phase + 1) % 4;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int value);
        exp_t e;
        e.kind = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling system-clock edge
    // ------------------------------------------------------------------
    initial begin : monitor
        int   low_cnt;
        bit   in_wait;
        bit   prev_busy;
        exp_t e;
        low_cnt = 0;
        in_wait = 0;
        prev_busy = 0;
        forever begin
            @(negedge clock);
            if (EXT_READY === 1'b0) begin
                in_wait = 1;
                if (cpu_pos) low_cnt++;
            end else if (in_wait) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wait_event: got wait of %0d with no expectation", low_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_WAIT) begin
                        errors++;
                        $display("FAIL wait_event: got wait of %0d expected cycle end", low_cnt);
                    end else if (low_cnt != e.value) begin
                        errors++;
                        $display("FAIL wait_len: got %0d expected %0d", low_cnt, e.value);
                    end else begin
                        $display("wait episode: %0d cpu clocks at %0t", low_cnt, $time);
                    end
                end
                in_wait = 0;
                low_cnt = 0;
            end
            if (prev_busy && (BUSY === 1'b0)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cycle_end: got busy fall with no expectation");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_END) begin
                        errors++;
                        $display("FAIL cycle_end: got busy fall expected wait of %0d", e.value);
                    end else begin
                        $display("bus cycle complete at %0t", $time);
                    end
                end
            end
            prev_busy = (BUSY === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after posedge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (EXT_READY !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        check(name, EXT_READY, 1);
    endtask

    // Advance until n CPU posedges have been consumed by the DUT.
    task automatic wait_pulses(input int n);
        int c;
        c = 0;
        while (c < n) begin
            if (cpu_pos) c++;
            tick(1);
        end
    endtask

    task automatic start_cycle(input logic io, input logic sel, input logic is_read,
                               input logic inta, input logic en);
        ALE = 1'b1;
        IO_OR_M = io;
        SELECT = sel;
        INTA_N = inta;
        ENABLE = en;
        tick(1);
        check("busy_armed", BUSY, 1);
        // Qualifiers change after ALE falls; they must not matter.
        ALE = 1'b0;
        SELECT = 1'b0;
        INTA_N = 1'b1;
        ENABLE = 1'b1;
        tick(1);
        if (is_read) RD_N = 1'b0;
        else WR_N = 1'b0;
        tick(1);
    endtask

    task automatic bus_cycle(input logic io, input logic sel, input logic is_read,
                             input logic inta, input logic en, input int n);
        if (n > 0) push(K_WAIT, n);
        push(K_END, 0);
        start_cycle(io, sel, is_read, inta, en);
        check("ready_at_strobe", EXT_READY, (n == 0) ? 1 : 0);
        wait_ready("ready_release");
        tick(1);
        check("busy_in_cycle", BUSY, 1);
        RD_N = 1'b1;
        WR_N = 1'b1;
        tick(1);
        check("busy_after_strobe", BUSY, 0);
        tick(3);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stimulus
        tick(3);
        check("reset_ready", EXT_READY, 1);
        check("reset_busy", BUSY, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(4);
            check("idle_ready", EXT_READY, 1);
            check("idle_busy", BUSY, 0);
        end

        // Selected I/O read: 4 waits
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4);
        // Selected memory write: 1 wait
        bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        // Unselected memory write: no waits, BUSY still tracks the cycle
        bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        // INTA cycle: no waits
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        // ENABLE low at ALE: no waits
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        // Abort after 2 posedges in WAIT
        push(K_WAIT, 2);
        push(K_END, 0);
        start_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("abort_ready_low", EXT_READY, 0);
        wait_pulses(2);
        RD_N = 1'b1;
        tick(1);
        check("abort_ready", EXT_READY, 1);
        check("abort_busy", BUSY, 0);
        tick(3);
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4);

        // Asynchronous reset after 2 of 4 waits
        push(K_WAIT, 2);
        push(K_END, 0);
        start_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_ready_low", EXT_READY, 0);
        wait_pulses(2);
        check("rst_still_low", EXT_READY, 0);
        reset = 1'b1;
        #1;
        check("async_rst_ready", EXT_READY, 1);
        check("async_rst_busy", BUSY, 0);
        RD_N = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);

        // Back-to-back: ALE in DONE as RD_N rises
        push(K_WAIT, 4);
        push(K_WAIT, 4);
        push(K_END, 0);
        start_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("b2b_first_low", EXT_READY, 0);
        wait_ready("b2b_first_release");
        RD_N = 1'b1;
        ALE = 1'b1;
        IO_OR_M = 1'b1;
        SELECT = 1'b1;
        tick(1);
        check("b2b_armed_busy", BUSY, 1);
        ALE = 1'b0;
        SELECT = 1'b0;
        tick(1);
        RD_N = 1'b0;
        tick(1);
        check("b2b_second_low", EXT_READY, 0);
        wait_ready("b2b_second_release");
        tick(1);
        RD_N = 1'b1;
        tick(1);
        check("b2b_busy_after", BUSY, 0);

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_wait_state_generator.md
Name: io_wait_state_generator

Overview:
- Generates the EXT_READY input of the CPU ready synchronizer by inserting a fixed number of CPU-clock wait states into selected 8088 bus cycles for slow expansion I/O and memory.
- Tracks each bus cycle from ALE through the RD_N/WR_N strobes.
- Pulls EXT_READY low for the configured count, then releases it.
- Sits upstream of the ready synchronizer and runs in the same system clock domain, using the cpu_clock_posedge/cpu_clock_negedge enables.

Parameters:
- IO_WAIT, 4, wait states for selected I/O cycles (IO_OR_M=1).
- MEM_WAIT, 1, wait states for selected memory cycles (IO_OR_M=0).
- COUNT_WIDTH, 4, width of the wait counter; IO_WAIT and MEM_WAIT must each be at most 2^COUNT_WIDTH-1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_clock_posedge  input  1  one-clock pulse at each CPU clock rising edge.
- cpu_clock_negedge  input  1  one-clock pulse at each CPU clock falling edge (unused by the FSM; present for interface symmetry with the ready synchronizer).
- ALE  input  1  address latch enable, active high.
- IO_OR_M  input  1  cycle type, qualified at ALE (1=I/O, 0=memory).
- SELECT  input  1  decoded slow-device select, qualified at ALE.
- RD_N  input  1  read strobe, active low.
- WR_N  input  1  write strobe, active low.
- INTA_N  input  1  interrupt acknowledge, active low.
- ENABLE  input  1  0 disables all wait insertion.
- EXT_READY  output  1  1 = no wait requested; 0 = hold the CPU.
- BUSY  output  1  1 when the FSM is not in IDLE.

Behaviour:
- All state is registered on posedge clock with asynchronous active-high reset.
- Reset values: state=IDLE, counter=0, latched type=0, latched select=0, EXT_READY=1, BUSY=0.
- strobe = ~RD_N | ~WR_N.
- FSM states and transitions:
  - IDLE: on any clock with ALE=1, latch IO_OR_M and (SELECT & ENABLE & INTA_N), then go to ARMED.
  - ARMED: while ALE=1, re-latch the type and select every clock (the last value before ALE falls wins).
  - ARMED, when ALE=0 and strobe=1:
    - If the latched select is 0, go to DONE; EXT_READY stays 1.
    - Otherwise load counter = IO_WAIT or MEM_WAIT according to the latched type.
    - If the loaded value is 0, go to DONE with EXT_READY=1.
    - Otherwise go to WAIT and set EXT_READY=0 on that same clock.
  - WAIT: on each cpu_clock_posedge, decrement the counter. On the clock where the counter goes from 1 to 0, set EXT_READY=1 and go to DONE.
    - Result: EXT_READY is low for exactly N cpu_clock_posedge events; the first decrement is the first posedge after entry.
  - WAIT with strobe=0 (cycle aborted): go to IDLE, EXT_READY=1, counter=0.
  - DONE: hold EXT_READY=1.
    - strobe=0 and ALE=0: go to IDLE.
    - strobe=0 and ALE=1: go directly to ARMED and latch as in IDLE (back-to-back cycles).
- ALE is ignored while in WAIT.
- Simultaneous ALE and strobe in IDLE: go to ARMED only; the strobe is honoured on a later clock, once ALE=0.
- INTA_N=0 at ALE forces latched select to 0; INTA cycles never receive waits here (the ready synchronizer handles them).
- ENABLE=0 sampled at ALE gives zero waits. Changing ENABLE during WAIT does not shorten the current wait.
- BUSY = (state != IDLE).
- Counter never underflows; decrements occur only in WAIT with counter>0.
- Reset asserted mid-WAIT forces EXT_READY=1 immediately (asynchronously).
- EXT_READY is a registered output; there is no combinational path from inputs to outputs.

Test Plan:
- Reset held, then released with all inputs idle -> EXT_READY=1, BUSY=0; both stay so for 20 CPU clocks.
- Selected I/O read (ALE pulse with IO_OR_M=1, SELECT=1, then RD_N=0 held) -> EXT_READY falls on the clock RD_N is seen; it returns to 1 on the 4th cpu_clock_posedge after that. RD_N rising then gives BUSY=0 on the next clock.
- Selected memory write (IO_OR_M=0, WR_N=0) -> EXT_READY low for exactly 1 cpu_clock_posedge. Repeat with SELECT=0 -> EXT_READY never falls, but BUSY asserts from ALE until WR_N rises.
- INTA cycle (INTA_N=0 at ALE, SELECT=1, RD_N=0) and ENABLE=0 I/O cycle -> EXT_READY stays 1 throughout both.
- Abort: I/O read with RD_N released after 2 posedges in WAIT -> EXT_READY=1 and state IDLE on the next clock. A following normal cycle then gets a full 4 waits.
- Reset asserted after 2 of 4 I/O waits -> EXT_READY=1 and BUSY=0 with no clock edge. Back-to-back: ALE in DONE right as RD_N rises -> ARMED directly, and the second cycle gets 4 waits.
